// File: rtl/ans_freq_table_ctrl_if.sv
// Count-load stream and symbol-lookup bus of the ANS frequency table
// controller. The master drives counts and lookup symbols, and the slave
// (the controller) returns ready and the lookup results.
interface ans_freq_table_ctrl_if #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 4,
    parameter int CUM_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] cnt_in;
    logic                 cnt_vld;
    logic                 cnt_rdy;
    logic [SYM_WIDTH-1:0] sym;
    logic [CNT_WIDTH-1:0] s_count;
    logic [CUM_WIDTH-1:0] s_cumulative;
    logic [CUM_WIDTH-1:0] total_count;

    modport master (
        output cnt_in, cnt_vld, sym,
        input  cnt_rdy, s_count, s_cumulative, total_count
    );

    modport slave (
        input  cnt_in, cnt_vld, sym,
        output cnt_rdy, s_count, s_cumulative, total_count
    );
endinterface

// File: rtl/ans_freq_table_ctrl.sv
// ANS frequency table controller. It loads 2**SYM_WIDTH symbol counts, then
// builds the exclusive prefix sums with a single adder (one entry per cycle),
// and then serves count/cumulative/total lookups. A start pulse aborts any
// load or scan in progress. Lookup outputs read as zero until the table is
// complete.
module ans_freq_table_ctrl #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 4,
    parameter int CUM_WIDTH = 8   // >= CNT_WIDTH+SYM_WIDTH, so the total cannot overflow
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    ans_freq_table_ctrl_if.slave    bus,
    output logic                    table_vld,
    output logic                    table_err,
    output logic                    busy
);
    localparam int DEPTH = 1 << SYM_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, READY} state_t;

    state_t               state_q, state_d;
    logic [SYM_WIDTH-1:0] idx_q, idx_d;        // load index in LOAD, scan index j in SCAN
    logic [CUM_WIDTH-1:0] acc_q, acc_d;
    logic [CUM_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0] counts_q [DEPTH];
    logic [CNT_WIDTH-1:0] counts_d [DEPTH];
    logic [CUM_WIDTH-1:0] cum_q    [DEPTH];
    logic [CUM_WIDTH-1:0] cum_d    [DEPTH];

    logic accept;
    logic last_idx;

    // start takes priority over a count offered in the same cycle, so that count is dropped
    assign accept   = (state_q == LOAD) && bus.cnt_vld && !start;
    assign last_idx = &idx_q;

    // State and table registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            total_q <= '0;
            // NOTE: the tables are small register arrays that are cleared on reset
            // so they never hold X. A RAM macro could not be reset this way.
            for (int i = 0; i < DEPTH; i++) begin
                counts_q[i] <= '0;
                cum_q[i]    <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            total_q  <= total_d;
            counts_q <= counts_d;
            cum_q    <= cum_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                LOAD:    if (accept && last_idx) state_d = SCAN;
                SCAN:    if (last_idx)           state_d = READY;
                READY:   state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: count capture during LOAD, one prefix-sum step per cycle during SCAN
    always_comb begin
        idx_d    = idx_q;
        acc_d    = acc_q;
        total_d  = total_q;
        counts_d = counts_q;
        cum_d    = cum_q;
        if (start) begin
            idx_d = '0;
            acc_d = '0;
        end else if (accept) begin
            counts_d[idx_q] = bus.cnt_in;
            idx_d           = idx_q + SYM_WIDTH'(1);   // wraps to 0 for the scan
        end else if (state_q == SCAN) begin
            cum_d[idx_q] = acc_q;
            acc_d        = acc_q + CUM_WIDTH'(counts_q[idx_q]);
            idx_d        = idx_q + SYM_WIDTH'(1);
            if (last_idx) begin
                total_d = acc_d;
            end
        end
    end

    // Outputs: status flags from the state, lookups gated by table validity
    always_comb begin
        bus.cnt_rdy      = (state_q == LOAD);
        busy             = (state_q == LOAD) || (state_q == SCAN);
        table_vld        = (state_q == READY);
        table_err        = (state_q == READY) && (total_q == '0);
        bus.s_count      = '0;
        bus.s_cumulative = '0;
        bus.total_count  = '0;
        if (state_q == READY) begin
            bus.s_count      = counts_q[bus.sym];
            bus.s_cumulative = cum_q[bus.sym];
            bus.total_count  = total_q;
        end
    end
endmodule

// File: tb/tb_ans_freq_table_ctrl.sv
// Self-checking bench for ans_freq_table_ctrl. Directed vectors come from a
// table, random tables are checked against a prefix-sum model, and
// hand-written sequences exercise abort and reset.
`timescale 1ns/1ps
module tb_ans_freq_table_ctrl;
    localparam int SYM_WIDTH = 4;
    localparam int CNT_WIDTH = 4;
    localparam int CUM_WIDTH = 8;
    localparam int DEPTH     = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic table_vld, table_err, busy;

    ans_freq_table_ctrl_if #(.SYM_WIDTH(SYM_WIDTH), .CNT_WIDTH(CNT_WIDTH), .CUM_WIDTH(CUM_WIDTH)) bus ();

    ans_freq_table_ctrl #(.SYM_WIDTH(SYM_WIDTH), .CNT_WIDTH(CNT_WIDTH), .CUM_WIDTH(CUM_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .table_vld (table_vld),
        .table_err (table_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] counts;     // nibble k = count of symbol k
        int          exp_total;
        bit          exp_err;
        int          exp_cum15;
    } vec_t;

    vec_t vecs[4];
    int   n_pass  = 0;
    int   n_total = 0;
    int   ref_counts[DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int ref_cum(input int s);
        int sum = 0;
        for (int k = 0; k < s; k++) sum += ref_counts[k];
        return sum;
    endfunction

    task automatic check_lookups(input string tag, input bit vld);
        for (int s = 0; s < DEPTH; s++) begin
            @(negedge clk);
            bus.sym = 4'(s);
            #1;
            check({tag, " s_count"},      bus.s_count,      vld ? ref_counts[s] : 0);
            check({tag, " s_cumulative"}, bus.s_cumulative, vld ? ref_cum(s) : 0);
            check({tag, " total_count"},  bus.total_count,  vld ? ref_cum(DEPTH) : 0);
        end
        check({tag, " table_vld"}, table_vld, vld);
        check({tag, " table_err"}, table_err, vld && (ref_cum(DEPTH) == 0));
    endtask

    task automatic do_start(input bit with_vld, input logic [3:0] v);
        @(negedge clk);
        start       = 1'b1;
        bus.cnt_vld = with_vld;
        bus.cnt_in  = v;
        @(negedge clk);
        start       = 1'b0;
        bus.cnt_vld = 1'b0;
    endtask

    // gap_mode: 0 = continuous valid, 1 = every other cycle, 2 = random
    task automatic feed(input logic [63:0] vals, input int n, input int gap_mode);
        int k   = 0;
        int cyc = 0;
        bit v;
        while (k < n && cyc < 200) begin
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.cnt_vld = v;
            bus.cnt_in  = v ? vals[4*k +: 4] : 4'($urandom);
            check("cnt_rdy in LOAD", bus.cnt_rdy, 1);
            @(negedge clk);
            if (v) begin
                ref_counts[k] = int'(vals[4*k +: 4]);
                k++;
            end
            cyc++;
        end
        bus.cnt_vld = 1'b0;
        if (k < n) check("feed timeout", k, n);
    endtask

    task automatic wait_ready();
        int lat = 0;
        check("cnt_rdy after last accept", bus.cnt_rdy, 0);
        check("busy in SCAN", busy, 1);
        while (!table_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("scan latency", lat, 16);
        check("busy in READY", busy, 0);
    endtask

    function automatic logic [63:0] rand_table();
        logic [63:0] r;
        for (int k = 0; k < DEPTH; k++) r[4*k +: 4] = 4'($urandom);
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"ones",      {16{4'h1}},            16,  1'b0, 15};
        vecs[1] = '{"fifteens",  {16{4'hF}},            240, 1'b0, 225};
        vecs[2] = '{"zeros",     64'h0,                 0,   1'b1, 0};
        vecs[3] = '{"irregular", 64'hA1D8_5B60_492F_1703, 95, 1'b0, 85};

        bus.cnt_in  = '0;
        bus.cnt_vld = 1'b0;
        bus.sym     = '0;
        for (int k = 0; k < DEPTH; k++) ref_counts[k] = 0;

        // Reset values
        #3;
        check("reset cnt_rdy",     bus.cnt_rdy,     0);
        check("reset busy",        busy,            0);
        check("reset table_vld",   table_vld,       0);
        check("reset table_err",   table_err,       0);
        check("reset total_count", bus.total_count, 0);
        #9 rst_n = 1'b1;

        // cnt_vld in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.cnt_vld = 1'b1;
            bus.cnt_in  = 4'h9;
            #1;
            check("idle cnt_rdy", bus.cnt_rdy, 0);
            check("idle busy",    busy,        0);
        end
        bus.cnt_vld = 1'b0;

        // Directed table vectors
        for (int t = 0; t < 4; t++) begin
            do_start(1'b0, 4'h0);
            feed(vecs[t].counts, 16, 0);
            wait_ready();
            check({vecs[t].name, " total"},     bus.total_count, vecs[t].exp_total);
            check({vecs[t].name, " table_err"}, table_err,       vecs[t].exp_err);
            @(negedge clk);
            bus.sym = 4'hF;
            #1;
            check({vecs[t].name, " cum15"}, bus.s_cumulative, vecs[t].exp_cum15);
            check_lookups(vecs[t].name, 1'b1);
        end

        // Gapped load of the irregular table, then cnt_vld in READY is ignored
        do_start(1'b0, 4'h0);
        feed(vecs[3].counts, 16, 1);
        wait_ready();
        check_lookups("gapped", 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.cnt_vld = 1'b1;
            bus.cnt_in  = 4'h9;
            #1;
            check("ready cnt_rdy", bus.cnt_rdy, 0);
        end
        bus.cnt_vld = 1'b0;
        check_lookups("ready after vld", 1'b1);

        // Random tables with random gaps
        for (int r = 0; r < 3; r++) begin
            do_start(1'b0, 4'h0);
            feed(rand_table(), 16, 2);
            wait_ready();
            check_lookups("random", 1'b1);
        end

        // Abort after 5 counts; restart carries a count that must be dropped
        do_start(1'b0, 4'h0);
        feed({16{4'h7}}, 5, 0);
        #1;
        check("midload table_vld", table_vld,       0);
        check("midload total",     bus.total_count, 0);
        do_start(1'b1, 4'hF);
        feed(rand_table(), 16, 0);
        wait_ready();
        check_lookups("abort load", 1'b1);

        // Abort at scan step j=8
        do_start(1'b0, 4'h0);
        feed(rand_table(), 16, 0);
        repeat (8) @(negedge clk);
        #1;
        check("midscan table_vld", table_vld,       0);
        check("midscan total",     bus.total_count, 0);
        check("midscan s_count",   bus.s_count,     0);
        check("midscan busy",      busy,            1);
        do_start(1'b0, 4'h0);
        check("restart cnt_rdy", bus.cnt_rdy, 1);
        repeat (20) @(negedge clk);
        check("restart no completion", table_vld, 0);
        feed(rand_table(), 16, 0);
        wait_ready();
        check_lookups("abort scan", 1'b1);

        // Asynchronous reset mid-LOAD
        do_start(1'b0, 4'h0);
        feed(rand_table(), 5, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst load cnt_rdy", bus.cnt_rdy, 0);
        check("rst load busy",    busy,        0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cnt_vld = 1'b1;
            @(negedge clk);
            check("post-reset cnt_rdy", bus.cnt_rdy, 0);
        end
        bus.cnt_vld = 1'b0;

        // Asynchronous reset in READY
        do_start(1'b0, 4'h0);
        feed(vecs[3].counts, 16, 0);
        wait_ready();
        bus.sym = 4'h5;
        #2 rst_n = 1'b0;
        #1;
        check("rst ready table_vld",    table_vld,        0);
        check("rst ready total",        bus.total_count,  0);
        check("rst ready s_count",      bus.s_count,      0);
        check("rst ready s_cumulative", bus.s_cumulative, 0);
        check("rst ready table_err",    table_err,        0);
        @(negedge clk);
        rst_n = 1'b1;
        check_lookups("after reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
